// File: rtl/mux_nxw_scan_if.sv
// rtl/mux_nxw_scan_if.sv - channel data, control and registered output bundle for mux_nxw_scan
interface mux_nxw_scan_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] din;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      en;
  logic [CHANNELS-1:0]       ch_mask;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          dout_ch;
  logic                      dout_valid;

  modport master (
    output din, sel, mode, en, ch_mask,
    input  dout, dout_ch, dout_valid
  );

  modport slave (
    input  din, sel, mode, en, ch_mask,
    output dout, dout_ch, dout_valid
  );
endinterface

// File: rtl/mux_nxw_scan.sv
// rtl/mux_nxw_scan.sv - registered N-channel W-bit mux with manual select and masked round-robin scan
module mux_nxw_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux_nxw_scan_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int DW_W  = $clog2(DWELL) + 1;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [DW_W-1:0]  dw_q, dw_d;

  logic             sel_ok;
  logic             ptr_hit;
  logic             dwell_last;
  logic [SEL_W-1:0] ptr_next;

  // Pick one channel out of the flattened bus; out-of-range indices read as zero.
  function automatic logic [WIDTH-1:0] chan_data(input logic [CHANNELS*WIDTH-1:0] d,
                                                 input logic [SEL_W-1:0] idx);
    chan_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) chan_data = d[k*WIDTH +: WIDTH];
    end
  endfunction

  // Nearest enabled channel after p going upward with wrap; p itself if it is the only one.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p,
                                                input logic [CHANNELS-1:0] m);
    logic             found;
    logic [SEL_W-1:0] idx;
    next_ptr = p;
    found    = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = SEL_W'((int'(p) + k) % CHANNELS);
      if (!found && m[idx]) begin
        next_ptr = idx;
        found    = 1'b1;
      end
    end
  endfunction

  assign sel_ok     = int'(bus.sel) < CHANNELS;
  assign ptr_hit    = bus.ch_mask[ptr_q];
  assign dwell_last = (dw_q == DW_W'(DWELL - 1));
  assign ptr_next   = next_ptr(ptr_q, bus.ch_mask);

  // Next-state selection: hold when disabled, otherwise manual select or one scan step.
  always_comb begin
    dout_d = dout_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    dw_d   = dw_q;
    if (bus.en) begin
      if (!bus.mode) begin
        dout_d = sel_ok ? chan_data(bus.din, bus.sel) : '0;
        ch_d   = bus.sel;
        vld_d  = sel_ok;
        ptr_d  = '0;
        dw_d   = '0;
      end else if (bus.ch_mask == '0) begin
        dout_d = '0;
        vld_d  = 1'b0;
      end else if (ptr_hit) begin
        dout_d = chan_data(bus.din, ptr_q);
        ch_d   = ptr_q;
        vld_d  = 1'b1;
        if (dwell_last) begin
          dw_d  = '0;
          ptr_d = ptr_next;
        end else begin
          dw_d  = dw_q + DW_W'(1);
        end
      end else begin
        // Current channel was masked off: spend one invalid cycle moving on.
        dout_d = '0;
        vld_d  = 1'b0;
        ptr_d  = ptr_next;
        dw_d   = '0;
      end
    end
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
      dw_q   <= '0;
    end else begin
      dout_q <= dout_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
      dw_q   <= dw_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_ch    = ch_q;
  assign bus.dout_valid = vld_q;
endmodule

// File: tb/tb_mux_nxw_scan.sv
// tb/tb_mux_nxw_scan.sv - scoreboard bench for mux_nxw_scan with 4-channel and 3-channel instances
module tb_mux_nxw_scan;
  localparam int DW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_nxw_scan_if #(.WIDTH(8), .CHANNELS(4)) b0 ();
  mux_nxw_scan_if #(.WIDTH(8), .CHANNELS(3)) b1 ();

  mux_nxw_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(DW)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  mux_nxw_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(DW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  typedef struct { int ptr; int dw; int d; int ch; bit v; } st_t;
  typedef struct { int d; int ch; bit v; } exp_t;

  exp_t      q0[$];
  exp_t      q1[$];
  st_t       s0, s1;
  int        n_chk  = 0;
  int        n_fail = 0;
  bit        mon_on = 1'b0;
  bit [31:0] din_v;
  bit        mode_r;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: one clock edge of a C-channel mux, written from the channel rules.
  function automatic st_t step(st_t s, int C, bit e, bit m, int sel, bit [3:0] mask, bit [31:0] d);
    st_t     n;
    bit [3:0] mk;
    int      nx;
    n = s;
    if (!e) return n;
    mk = mask & 4'((1 << C) - 1);
    if (!m) begin
      n.ch  = sel;
      n.ptr = 0;
      n.dw  = 0;
      if (sel < C) begin n.d = int'((d >> (8 * sel)) & 32'hff); n.v = 1'b1; end
      else begin n.d = 0; n.v = 1'b0; end
    end else if (mk == 4'd0) begin
      n.d = 0;
      n.v = 1'b0;
    end else begin
      nx = s.ptr;
      for (int k = C; k >= 1; k--) if (mk[(s.ptr + k) % C]) nx = (s.ptr + k) % C;
      if (mk[s.ptr]) begin
        n.d  = int'((d >> (8 * s.ptr)) & 32'hff);
        n.ch = s.ptr;
        n.v  = 1'b1;
        if (s.dw == DW - 1) begin n.dw = 0; n.ptr = nx; end
        else n.dw = s.dw + 1;
      end else begin
        n.d   = 0;
        n.v   = 1'b0;
        n.ptr = nx;
        n.dw  = 0;
      end
    end
    return n;
  endfunction

  function automatic exp_t to_exp(st_t s);
    exp_t e;
    e.d  = s.d;
    e.ch = s.ch;
    e.v  = s.v;
    return e;
  endfunction

  task automatic drive(bit e, bit m, int sel, bit [3:0] mask);
    @(negedge clk);
    rst_n      = 1'b1;
    b0.en      = e;        b1.en      = e;
    b0.mode    = m;        b1.mode    = m;
    b0.sel     = 2'(sel);  b1.sel     = 2'(sel);
    b0.ch_mask = mask;     b1.ch_mask = mask[2:0];
    b0.din     = din_v;    b1.din     = din_v[23:0];
    s0 = step(s0, 4, e, m, sel, mask, din_v);
    s1 = step(s1, 3, e, m, sel, mask, din_v);
    q0.push_back(to_exp(s0));
    q1.push_back(to_exp(s1));
    mon_on = 1'b1;
  endtask

  task automatic reset_mid();
    st_t z;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_dout0",  int'(b0.dout), 0);
    check("rst_ch0",    int'(b0.dout_ch), 0);
    check("rst_valid0", int'(b0.dout_valid), 0);
    check("rst_dout1",  int'(b1.dout), 0);
    check("rst_valid1", int'(b1.dout_valid), 0);
    z  = '{0, 0, 0, 0, 1'b0};
    s0 = z;
    s1 = z;
    q0.push_back(to_exp(z));
    q1.push_back(to_exp(z));
    mon_on = 1'b1;
  endtask

  task automatic lit(int inst, int d, int c, bit v);
    @(posedge clk);
    #2;
    if (inst == 0) begin
      check("lit_dout0", int'(b0.dout), d);
      check("lit_ch0", int'(b0.dout_ch), c);
      check("lit_valid0", int'(b0.dout_valid), int'(v));
    end else begin
      check("lit_dout1", int'(b1.dout), d);
      check("lit_ch1", int'(b1.dout_ch), c);
      check("lit_valid1", int'(b1.dout_valid), int'(v));
    end
  endtask

  // Monitor: every edge after the first stimulus, pop and compare both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: q0=%0d q1=%0d entries, required at least 1 each", q0.size(), q1.size());
        end else begin
          e = q0.pop_front();
          check("sb_dout0", int'(b0.dout), e.d);
          check("sb_ch0", int'(b0.dout_ch), e.ch);
          check("sb_valid0", int'(b0.dout_valid), int'(e.v));
          e = q1.pop_front();
          check("sb_dout1", int'(b1.dout), e.d);
          check("sb_ch1", int'(b1.dout_ch), e.ch);
          check("sb_valid1", int'(b1.dout_valid), int'(e.v));
        end
      end
    end
  end

  initial begin
    int fd[9] = '{'h11, 'h11, 'h22, 'h22, 'h33, 'h33, 'h44, 'h44, 'h11};
    int fc[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int sd[7] = '{'h00, 'h22, 'h22, 'h44, 'h44, 'h22, 'h22};
    int sc[7] = '{0, 1, 1, 3, 3, 1, 1};
    int td[7] = '{'h11, 'h11, 'h22, 'h22, 'h33, 'h33, 'h11};
    int tc[7] = '{0, 0, 1, 1, 2, 2, 0};

    rst_n = 1'b1;
    b0.en = 0; b0.mode = 0; b0.sel = 0; b0.ch_mask = 0; b0.din = 0;
    b1.en = 0; b1.mode = 0; b1.sel = 0; b1.ch_mask = 0; b1.din = 0;
    din_v  = 32'h4433_2211;
    mode_r = 1'b0;
    reset_mid();

    // Manual select of every channel.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i, 4'hf);
      lit(0, int'((din_v >> (8 * i)) & 32'hff), i, 1'b1);
    end

    // Reset between edges while dout shows channel 2.
    drive(1, 0, 2, 4'hf);
    lit(0, 'h33, 2, 1'b1);
    reset_mid();

    // Full-mask scan with wrap.
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 0, 4'hf);
      lit(0, fd[i], fc[i], 1'b1);
    end

    // Sparse mask after a manual cycle: one bubble then channels 1 and 3.
    drive(1, 0, 0, 4'hf);
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 0, 4'ha);
      lit(0, sd[i], sc[i], i != 0);
    end
    drive(1, 1, 0, 4'ha);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 4'h4);

    // Freeze after the first channel-1 output, then empty mask.
    drive(1, 0, 0, 4'hf);
    drive(1, 1, 0, 4'hf); lit(0, 'h11, 0, 1'b1);
    drive(1, 1, 0, 4'hf); lit(0, 'h11, 0, 1'b1);
    drive(1, 1, 0, 4'hf); lit(0, 'h22, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 4'hf);
      lit(0, 'h22, 1, 1'b1);
    end
    drive(1, 1, 0, 4'hf); lit(0, 'h22, 1, 1'b1);
    drive(1, 1, 0, 4'hf); lit(0, 'h33, 2, 1'b1);
    drive(1, 1, 0, 4'h0); lit(0, 'h00, 2, 1'b0);
    drive(1, 1, 0, 4'h0); lit(0, 'h00, 2, 1'b0);
    drive(1, 1, 0, 4'hf);
    drive(1, 1, 0, 4'hf);

    // Three-channel instance: out-of-range select, then scan wrapping 2 -> 0.
    drive(1, 0, 3, 4'hf);
    lit(1, 'h00, 3, 1'b0);
    drive(1, 0, 0, 4'hf);
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 0, 4'hf);
      lit(1, td[i], tc[i], 1'b1);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_mid();
      end else begin
        din_v = $urandom;
        if ($urandom_range(0, 9) == 0) mode_r = ~mode_r;
        drive($urandom_range(0, 7) != 0, mode_r, int'($urandom_range(0, 3)), 4'($urandom));
      end
    end

    @(posedge clk);
    #3;
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: q0=%0d q1=%0d entries left, required 0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
